pc_seq_ctrl: RTL
================

Name: pc_seq_ctrl

Overview:
- Pipeline sequencing controller for the fetch PC register and the five downstream stages (IF, ID, EX, MEM, WB).
- Merges stall requests from ID, EX and MEM into a per-stage stall vector.
- Redirects the PC on a taken branch or an exception, and drives a multi-cycle pipeline flush on exceptions.
- Tracks consecutive stall cycles and raises a sticky timeout flag for debug.

Parameters:
- FLUSH_CYCLES, 2, number of cycles `flush` stays high after an exception (legal range 1..15).
- MAX_STALL, 64, consecutive-stall count at which `stall_timeout` sets (legal range 1..255).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- stallreq_id  input  1  ID stage requests a hold.
- stallreq_ex  input  1  EX stage requests a hold (e.g. multi-cycle op).
- stallreq_mem  input  1  MEM stage requests a hold.
- branch_flag  input  1  ID resolved a taken branch this cycle.
- branch_target  input  32  branch destination address.
- excp_valid  input  1  exception raised this cycle.
- excp_vector  input  32  exception handler address.
- stall  output  6  hold vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- flush  output  1  clear all pipeline registers.
- pc_load  output  1  PC register loads `new_pc` instead of PC+4.
- new_pc  output  32  redirect address.
- stall_timeout  output  1  sticky: stall held for MAX_STALL consecutive cycles.

Behaviour:
- States: RUN, STALL, FLUSH. A 4-bit flush counter `fcnt` and an 8-bit saturating stall counter `scnt`.
- Reset (rst=1 at clock edge):
  - state=RUN, fcnt=0, scnt=0, stall_timeout=0, excp_vector_q=0.
  - While rst is high, every output is forced to 0 regardless of inputs.
- Stall vector, combinational, valid in RUN and STALL only. Priority is MEM > EX > ID.
  - stallreq_mem → 6'b011111.
  - else stallreq_ex → 6'b001111.
  - else stallreq_id → 6'b000111.
  - else 6'b000000.
  - In FLUSH, stall=0 and all stall requests are ignored.
- Exception handling:
  - excp_valid in RUN or STALL has priority over stall and branch.
  - In that same cycle: stall=0, pc_load=0.
  - Next edge: state→FLUSH, excp_vector_q←excp_vector, fcnt←FLUSH_CYCLES−1.
- FLUSH state:
  - flush=1 every cycle.
  - pc_load=1 and new_pc=excp_vector_q only in the first FLUSH cycle (fcnt==FLUSH_CYCLES−1).
  - fcnt decrements each cycle; when fcnt==0, next state is RUN.
  - excp_valid and branch_flag are ignored in FLUSH.
  - Exception latency: flush spans cycles N+1..N+FLUSH_CYCLES; PC redirect occurs at cycle N+1.
- Branch handling, combinational, in RUN or STALL:
  - Condition: branch_flag=1, excp_valid=0, and stall[2]=0. Then pc_load=1 and new_pc=branch_target in the same cycle.
  - If stall[2]=1, the branch is ignored; ID re-presents it after the stall.
  - Otherwise pc_load=0 and new_pc=0.
- RUN/STALL transitions (when no exception):
  - Next state is STALL if stall≠0, else RUN.
- Stall counter `scnt`:
  - Increments at each edge where stall≠0, saturating at 255.
  - Clears to 0 at any edge where stall==0, including every FLUSH cycle.
  - stall_timeout sets at the edge where scnt+1==MAX_STALL and remains set until rst.
- Simultaneous events:
  - excp_valid together with a stall request: exception wins and stall=0.
  - rst together with anything: reset wins.
- Reset mid-FLUSH: aborts the flush; next cycle is RUN with all outputs 0.

Test Plan:
- Reset: rst=1 for 2 cycles with all requests high → stall=0, flush=0, pc_load=0, new_pc=0, stall_timeout=0; state RUN after release.
- Priority: stallreq_id=1 and stallreq_ex=1 together → stall=6'b001111; drop stallreq_ex → stall=6'b000111 in the same cycle.
- Branch: branch_flag=1, branch_target=0x0000_0040, no stall → pc_load=1, new_pc=0x40 same cycle. Repeat with stallreq_id=1 → pc_load=0, stall=6'b000111.
- Exception during stall: stallreq_mem=1 and excp_valid=1, excp_vector=0x0000_0020 at cycle N → stall=0 at N; flush=1 at N+1 and N+2 (FLUSH_CYCLES=2); pc_load=1, new_pc=0x20 only at N+1; state RUN at N+3. A second excp_valid at N+1 has no effect.
- Timeout: hold stallreq_ex=1 for 64 cycles → stall_timeout rises after the 64th stalled edge and stays high after the request drops; rst clears it.
- Reset mid-flush: assert rst at the second FLUSH cycle → flush=0 the same cycle; after release, RUN with no pc_load.

Source files
------------

// File: rtl/pc_seq_ctrl_if.sv
// Request/redirect bundle between the pipeline stages and the sequencing controller.
// The pipeline side drives requests (master); the controller answers with stall/flush/redirect (slave).
interface pc_seq_ctrl_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        excp_valid;
    logic [31:0] excp_vector;
    logic [5:0]  stall;
    logic        flush;
    logic        pc_load;
    logic [31:0] new_pc;
    logic        stall_timeout;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem,
        output branch_flag, branch_target, excp_valid, excp_vector,
        input  stall, flush, pc_load, new_pc, stall_timeout
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem,
        input  branch_flag, branch_target, excp_valid, excp_vector,
        output stall, flush, pc_load, new_pc, stall_timeout
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Pipeline sequencing controller: merges stall requests, redirects the PC on branches
// and exceptions, runs a multi-cycle flush after an exception and watches for stuck stalls.
module pc_seq_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MAX_STALL    = 64
) (
    input logic         clk,
    input logic         rst,
    pc_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam logic [3:0] FLUSH_LAST  = 4'(FLUSH_CYCLES - 1);
    localparam logic [8:0] STALL_LIMIT = 9'(MAX_STALL);

    state_e      state_q, state_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic [7:0]  scnt_q, scnt_d;
    logic        timeout_q, timeout_d;
    logic [31:0] excpVector_q, excpVector_d;

    logic [5:0]  stallVec;
    logic        flushOut;
    logic        pcLoad;
    logic [31:0] newPc;
    logic [8:0]  scntNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            fcnt_q       <= '0;
            scnt_q       <= '0;
            timeout_q    <= 1'b0;
            excpVector_q <= '0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            scnt_q       <= scnt_d;
            timeout_q    <= timeout_d;
            excpVector_q <= excpVector_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        excpVector_d = excpVector_q;
        timeout_d    = timeout_q;
        scnt_d       = '0;
        scntNext     = {1'b0, scnt_q} + 9'd1;

        case (state_q)
            FLUSH: begin
                if (fcnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: begin
                if (bus.excp_valid) begin
                    state_d      = FLUSH;
                    fcnt_d       = FLUSH_LAST;
                    excpVector_d = bus.excp_vector;
                end else begin
                    state_d = (stallVec != 6'd0) ? STALL : RUN;
                end
            end
        endcase

        // Counter runs only across unbroken stall edges; any idle edge (incl. FLUSH) restarts it.
        if (stallVec != 6'd0) begin
            scnt_d = (scnt_q == 8'hFF) ? scnt_q : scntNext[7:0];
            if (scntNext == STALL_LIMIT) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_comb begin
        stallVec = '0;
        flushOut = 1'b0;
        pcLoad   = 1'b0;
        newPc    = '0;

        if (!rst) begin
            if (state_q == FLUSH) begin
                flushOut = 1'b1;
                if (fcnt_q == FLUSH_LAST) begin
                    pcLoad = 1'b1;
                    newPc  = excpVector_q;
                end
            end else if (!bus.excp_valid) begin
                if (bus.stallreq_mem) begin
                    stallVec = 6'b011111;
                end else if (bus.stallreq_ex) begin
                    stallVec = 6'b001111;
                end else if (bus.stallreq_id) begin
                    stallVec = 6'b000111;
                end
                // A branch seen while ID is held is dropped; ID presents it again later.
                if (bus.branch_flag && !stallVec[2]) begin
                    pcLoad = 1'b1;
                    newPc  = bus.branch_target;
                end
            end
        end
    end

    assign bus.stall         = stallVec;
    assign bus.flush         = flushOut;
    assign bus.pc_load       = pcLoad;
    assign bus.new_pc        = newPc;
    assign bus.stall_timeout = timeout_q & ~rst;

endmodule
